bound_flasher: RTL and testbench



---
 rtl/bound_flasher_pkg.sv | 33 +++
 rtl/bound_flasher.sv | 109 ++++++++++
 tb/tb_bound_flasher.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/bound_flasher_pkg.sv
// Shared types and lamp-pattern constants for the bound flasher sequencer.
// The one-lamp shift helpers are used by the next-state logic.
package bound_flasher_pkg;

    localparam int NUM_LEDS = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        S4   = 3'd4,
        S5   = 3'd5,
        S6   = 3'd6
    } state_t;

    localparam logic [15:0] ALL_OFF   = 16'h0000;
    localparam logic [15:0] LOW5      = 16'h001F;
    localparam logic [15:0] LAMP5_ON  = 16'h003F;
    localparam logic [15:0] LAMP10_ON = 16'h07FF;
    localparam logic [15:0] ALL_ON    = 16'hFFFF;

    // Light the next lamp above the current lit run.
    function automatic logic [15:0] on_step(input logic [15:0] led);
        return {led[14:0], 1'b1};
    endfunction

    // Extinguish the highest lit lamp.
    function automatic logic [15:0] off_step(input logic [15:0] led);
        return {1'b0, led[15:1]};
    endfunction

endpackage

// File: rtl/bound_flasher.sv
// Bound flasher: 16-lamp fill/drain sequencer started by flick, with
// kickback to the previous phase when flick is held at lamp5/lamp10 while filling.
module bound_flasher
    import bound_flasher_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flick,
    output logic [NUM_LEDS-1:0] LED
);

    state_t      state_r;
    state_t      next_state_s;
    logic [15:0] next_led_s;
    logic        kick_s;

    assign kick_s = flick && ((LED == LAMP5_ON) || (LED == LAMP10_ON));

    // Next-state and next-lamp pattern; a phase change and its first step share one edge.
    always_comb begin
        next_state_s = state_r;
        next_led_s   = LED;
        case (state_r)
            IDLE: begin
                if (flick) begin
                    next_state_s = S1;
                    next_led_s   = on_step(LED);
                end else begin
                    next_state_s = IDLE;
                    next_led_s   = ALL_OFF;
                end
            end
            S1: begin
                if (LED == LAMP5_ON) begin
                    next_state_s = S2;
                    next_led_s   = off_step(LED);
                end else begin
                    next_led_s   = on_step(LED);
                end
            end
            S2: begin
                if (LED == ALL_OFF) begin
                    next_state_s = S3;
                    next_led_s   = on_step(LED);
                end else begin
                    next_led_s   = off_step(LED);
                end
            end
            S3: begin
                if (kick_s) begin
                    next_state_s = S2;
                    next_led_s   = off_step(LED);
                end else if (LED == LAMP10_ON) begin
                    next_state_s = S4;
                    next_led_s   = off_step(LED);
                end else begin
                    next_led_s   = on_step(LED);
                end
            end
            S4: begin
                if (LED == LOW5) begin
                    next_state_s = S5;
                    next_led_s   = on_step(LED);
                end else begin
                    next_led_s   = off_step(LED);
                end
            end
            S5: begin
                if (kick_s) begin
                    next_state_s = S4;
                    next_led_s   = off_step(LED);
                end else if (LED == ALL_ON) begin
                    next_state_s = S6;
                    next_led_s   = off_step(LED);
                end else begin
                    next_led_s   = on_step(LED);
                end
            end
            S6: begin
                // Drained: a pending flick restarts the fill without an idle cycle.
                if (LED != ALL_OFF) begin
                    next_led_s   = off_step(LED);
                end else if (flick) begin
                    next_state_s = S1;
                    next_led_s   = on_step(LED);
                end else begin
                    next_state_s = IDLE;
                    next_led_s   = ALL_OFF;
                end
            end
            default: begin
                next_state_s = IDLE;
                next_led_s   = ALL_OFF;
            end
        endcase
    end

    // State and lamp registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            LED     <= ALL_OFF;
        end else begin
            state_r <= next_state_s;
            LED     <= next_led_s;
        end
    end

endmodule

// File: tb/tb_bound_flasher.sv
// Directed bench for bound_flasher: expected lamp patterns are built from
// phase segments (fill/drain lengths) and compared every clock.
module tb_bound_flasher;

    logic        clk;
    logic        rst_n;
    logic        flick;
    logic [15:0] LED;

    int          n_cmp;
    int          n_fail;
    logic [15:0] exp_q[$];
    logic [15:0] cur;

    bound_flasher dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flick(flick),
        .LED  (LED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Append n expected values, each one lamp on (fill) or off (drain) from the last.
    task automatic add_seg(input bit on, input int n);
        for (int i = 0; i < n; i++) begin
            cur = on ? {cur[14:0], 1'b1} : {1'b0, cur[15:1]};
            exp_q.push_back(cur);
        end
    endtask

    task automatic start_pattern();
        exp_q.delete();
        cur = 16'h0000;
    endtask

    task automatic apply_reset();
        flick = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        flick = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (LED !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_async: LED=%h expected 0000", LED);
        end
        #5 rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_cmp++;
            if (LED !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: LED=%h expected 0000", c, LED);
            end
        end
    endtask

    task automatic test_nominal();
        apply_reset();
        start_pattern();
        add_seg(1'b1, 6); add_seg(1'b0, 6); add_seg(1'b1, 11);
        add_seg(1'b0, 6); add_seg(1'b1, 11); add_seg(1'b0, 16);
        for (int i = 0; i < 6; i++) exp_q.push_back(16'h0000);
        for (int e = 1; e <= exp_q.size(); e++) begin
            flick = (e == 1);
            @(negedge clk);
            n_cmp++;
            if (LED !== exp_q[e-1]) begin
                n_fail++;
                $display("FAIL nominal edge %0d: LED=%h expected %h", e, LED, exp_q[e-1]);
            end
        end
    endtask

    task automatic test_kick_s3();
        apply_reset();
        start_pattern();
        add_seg(1'b1, 6); add_seg(1'b0, 6); add_seg(1'b1, 6);
        add_seg(1'b0, 6); add_seg(1'b1, 11); add_seg(1'b0, 6);
        add_seg(1'b1, 11); add_seg(1'b0, 16);
        for (int e = 1; e <= exp_q.size(); e++) begin
            flick = (e == 1) || (e == 19);
            @(negedge clk);
            n_cmp++;
            if (LED !== exp_q[e-1]) begin
                n_fail++;
                $display("FAIL kick_s3 edge %0d: LED=%h expected %h", e, LED, exp_q[e-1]);
            end
        end
    endtask

    task automatic test_kick_s3_top();
        apply_reset();
        start_pattern();
        add_seg(1'b1, 6); add_seg(1'b0, 6); add_seg(1'b1, 11);
        add_seg(1'b0, 11); add_seg(1'b1, 11); add_seg(1'b0, 6);
        add_seg(1'b1, 11); add_seg(1'b0, 16);
        for (int e = 1; e <= exp_q.size(); e++) begin
            flick = (e == 1) || (e == 24);
            @(negedge clk);
            n_cmp++;
            if (LED !== exp_q[e-1]) begin
                n_fail++;
                $display("FAIL kick_s3_top edge %0d: LED=%h expected %h", e, LED, exp_q[e-1]);
            end
        end
    endtask

    task automatic test_kick_s5();
        apply_reset();
        start_pattern();
        add_seg(1'b1, 6); add_seg(1'b0, 6); add_seg(1'b1, 11);
        add_seg(1'b0, 6); add_seg(1'b1, 6); add_seg(1'b0, 6);
        add_seg(1'b1, 11); add_seg(1'b0, 16);
        for (int e = 1; e <= exp_q.size(); e++) begin
            flick = (e == 1) || (e == 36);
            @(negedge clk);
            n_cmp++;
            if (LED !== exp_q[e-1]) begin
                n_fail++;
                $display("FAIL kick_s5 edge %0d: LED=%h expected %h", e, LED, exp_q[e-1]);
            end
        end
    endtask

    task automatic test_ignore_flick();
        apply_reset();
        start_pattern();
        add_seg(1'b1, 6); add_seg(1'b0, 6); add_seg(1'b1, 11);
        add_seg(1'b0, 6); add_seg(1'b1, 11); add_seg(1'b0, 16);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h0000);
        for (int e = 1; e <= exp_q.size(); e++) begin
            flick = (e <= 13) || (e >= 25 && e <= 30) || (e >= 42 && e <= 56);
            @(negedge clk);
            n_cmp++;
            if (LED !== exp_q[e-1]) begin
                n_fail++;
                $display("FAIL ignore_flick edge %0d: LED=%h expected %h", e, LED, exp_q[e-1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        start_pattern();
        for (int r = 0; r < 2; r++) begin
            add_seg(1'b1, 6); add_seg(1'b0, 6); add_seg(1'b1, 11);
            add_seg(1'b0, 6); add_seg(1'b1, 11); add_seg(1'b0, 16);
        end
        for (int e = 1; e <= exp_q.size(); e++) begin
            flick = (e == 1) || (e == 57);
            @(negedge clk);
            n_cmp++;
            if (LED !== exp_q[e-1]) begin
                n_fail++;
                $display("FAIL back_to_back edge %0d: LED=%h expected %h", e, LED, exp_q[e-1]);
            end
        end
    endtask

    task automatic test_flick_held();
        apply_reset();
        start_pattern();
        for (int r = 0; r < 5; r++) begin
            add_seg(1'b1, 6); add_seg(1'b0, 6);
        end
        add_seg(1'b1, 2);
        flick = 1'b1;
        for (int e = 1; e <= exp_q.size(); e++) begin
            @(negedge clk);
            n_cmp++;
            if (LED !== exp_q[e-1]) begin
                n_fail++;
                $display("FAIL flick_held edge %0d: LED=%h expected %h", e, LED, exp_q[e-1]);
            end
        end
        // LED is 0003 here; a 10 ns reset pulse spanning one rising edge must clear it at once.
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (LED !== 16'h0000) begin
            n_fail++;
            $display("FAIL held_async_reset: LED=%h expected 0000", LED);
        end
        #8;
        n_cmp++;
        if (LED !== 16'h0000) begin
            n_fail++;
            $display("FAIL held_reset_hold: LED=%h expected 0000", LED);
        end
        #1 rst_n = 1'b1;
        start_pattern();
        add_seg(1'b1, 6); add_seg(1'b0, 6); add_seg(1'b1, 6); add_seg(1'b0, 3);
        for (int e = 1; e <= exp_q.size(); e++) begin
            @(negedge clk);
            n_cmp++;
            if (LED !== exp_q[e-1]) begin
                n_fail++;
                $display("FAIL held_restart edge %0d: LED=%h expected %h", e, LED, exp_q[e-1]);
            end
        end
        flick = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b1;
        flick  = 1'b0;
        cur    = 16'h0000;
        test_reset();
        test_nominal();
        test_kick_s3();
        test_kick_s3_top();
        test_kick_s5();
        test_ignore_flick();
        test_back_to_back();
        test_flick_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
